// File: rtl/cordic_pkg.sv
// Shared CORDIC constants for the rotation and vectoring engines: atan table, gain, angle limits, FSM states.
// Angles are degrees*2^16; lengths are Q16.16.
package cordic_pkg;

    localparam int ITER_MAX = 16;

    localparam logic [31:0]        K_GAIN = 32'h0000_9B74;
    localparam logic signed [31:0] DEG90  = 32'sd5898240;
    localparam logic signed [31:0] DEG180 = 32'sd11796480;
    localparam logic signed [31:0] DEG360 = 32'sd23592960;

    localparam logic signed [31:0] ATAN_TAB [0:ITER_MAX-1] = '{
        32'sd2949120, 32'sd1740992, 32'sd919872, 32'sd466944,
        32'sd234368,  32'sd117312,  32'sd58688,  32'sd29312,
        32'sd14656,   32'sd7360,    32'sd3648,   32'sd1856,
        32'sd896,     32'sd448,     32'sd256,    32'sd128
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_POST = 2'd2
    } state_t;

    function automatic logic signed [31:0] atan_lut(input logic [3:0] idx);
        return ATAN_TAB[idx];
    endfunction

endpackage

// File: rtl/cordic_vec_iter.sv
// One vectoring micro-rotation that drives y toward zero; purely combinational.
// Latency 0; no flow control, the owning FSM decides when the result is captured.
module cordic_vec_iter (
    input  logic signed [31:0] x,
    input  logic signed [31:0] y,
    input  logic signed [31:0] z,
    input  logic        [3:0]  shift,
    input  logic signed [31:0] atan,
    output logic signed [31:0] x_nxt,
    output logic signed [31:0] y_nxt,
    output logic signed [31:0] z_nxt
);

    logic signed [31:0] xs;
    logic signed [31:0] ys;

    assign xs = x >>> shift;
    assign ys = y >>> shift;

    // y >= 0 rotates clockwise (angle accumulates up), y < 0 anticlockwise
    always_comb begin
        if (!y[31]) begin
            x_nxt = x + ys;
            y_nxt = y - xs;
            z_nxt = z + atan;
        end else begin
            x_nxt = x - ys;
            y_nxt = y + xs;
            z_nxt = z - atan;
        end
    end

endmodule

// File: rtl/cordic_vec.sv
// Iterative vectoring CORDIC: (x,y) Q16.16 -> atan2 in degrees*2^16 and K-compensated magnitude.
// Latency ITER+1 edges from accept to done; vld is only honoured in IDLE, requests while busy are dropped.
module cordic_vec #(
    parameter int          ITER   = 16,
    parameter logic [31:0] K_GAIN = cordic_pkg::K_GAIN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [31:0] x_in,
    input  logic signed [31:0] y_in,
    output logic               busy,
    output logic               done,
    output logic signed [31:0] angle,
    output logic        [31:0] magnitude
);
    import cordic_pkg::*;

    state_t             state;
    logic        [4:0]  cnt;
    logic signed [31:0] x_q, y_q, z_q;
    logic               zero_q;

    logic signed [31:0] fx, fy, fz;
    logic signed [31:0] x_nxt, y_nxt, z_nxt;
    logic signed [31:0] atan_i;
    logic signed [47:0] x_ext, k_ext, prod;

    // Fold left-half-plane inputs by +/-90 deg so the core only sees x >= 0
    always_comb begin
        fx = x_in;
        fy = y_in;
        fz = '0;
        if (x_in[31]) begin
            if (!y_in[31]) begin
                fx = y_in;
                fy = -x_in;
                fz = DEG90;
            end else begin
                fx = -y_in;
                fy = x_in;
                fz = -DEG90;
            end
        end
    end

    assign atan_i = atan_lut(cnt[3:0]);

    cordic_vec_iter u_iter (
        .x     (x_q),
        .y     (y_q),
        .z     (z_q),
        .shift (cnt[3:0]),
        .atan  (atan_i),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    assign x_ext = 48'(x_q);
    assign k_ext = 48'(K_GAIN);
    assign prod  = x_ext * k_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            zero_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            angle     <= '0;
            magnitude <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (vld) begin
                        x_q    <= fx;
                        y_q    <= fy;
                        z_q    <= fz;
                        zero_q <= (x_in == '0) && (y_in == '0);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                    z_q <= z_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1))
                        state <= ST_POST;
                end
                ST_POST: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (zero_q) begin
                        angle     <= '0;
                        magnitude <= '0;
                    end else begin
                        angle     <= (z_q > DEG180) ? (z_q - DEG360) : z_q;
                        magnitude <= prod[47:16];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
